// File: rtl/encoder_speed_filter.sv
// Moving-average and stall detector for encoder window counts.
// Define FILTER_MINMAX_EN to add Max_out/Min_out sample extremes.
module encoder_speed_filter #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH_LOG2    = 3,
  parameter int unsigned STALL_WINDOWS = 4
) (
  input  logic                        OUT_CLK,
  input  logic                        RST,
  input  logic [WIDTH-1:0]            Count_in,
  input  logic                        En_in,
  input  logic                        Clear,
  output logic [WIDTH+DEPTH_LOG2-1:0] Sum,
  output logic [WIDTH-1:0]            Avg,
  output logic                        Avg_valid,
  output logic                        Filled,
`ifdef FILTER_MINMAX_EN
  output logic [WIDTH-1:0]            Max_out,
  output logic [WIDTH-1:0]            Min_out,
`endif
  output logic                        Stall
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned SumW  = WIDTH + DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FillMax  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [7:0]          StallMax = 8'(STALL_WINDOWS);

  logic [WIDTH-1:0]      samples_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2:0]   fill_q;
  logic [7:0]            zero_run_q;

  logic [SumW-1:0]     sum_d;
  logic [DEPTH_LOG2:0] fill_d;
  logic                full_d;
  logic [7:0]          zero_run_d;

  // Unfilled entries read as zero, so the add/subtract is exact from the start.
  always_comb begin
    sum_d = Sum + {{DEPTH_LOG2{1'b0}}, Count_in} - {{DEPTH_LOG2{1'b0}}, samples_q[wr_ptr_q]};
    fill_d = (fill_q == FillMax) ? fill_q : fill_q + (DEPTH_LOG2 + 1)'(1);
    full_d = (fill_d == FillMax);
    if (Count_in != '0) begin
      zero_run_d = 8'd0;
    end else if (zero_run_q == StallMax) begin
      zero_run_d = zero_run_q;
    end else begin
      zero_run_d = zero_run_q + 8'd1;
    end
  end

  always_ff @(posedge OUT_CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(Depth); i++) samples_q[i] <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      zero_run_q <= '0;
      Sum        <= '0;
      Avg        <= '0;
      Avg_valid  <= 1'b0;
      Filled     <= 1'b0;
      Stall      <= 1'b0;
`ifdef FILTER_MINMAX_EN
      Max_out    <= '0;
      Min_out    <= '1;
`endif
    end else if (Clear) begin
      for (int i = 0; i < int'(Depth); i++) samples_q[i] <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      zero_run_q <= '0;
      Sum        <= '0;
      Avg        <= '0;
      Avg_valid  <= 1'b0;
      Filled     <= 1'b0;
      Stall      <= 1'b0;
`ifdef FILTER_MINMAX_EN
      Max_out    <= '0;
      Min_out    <= '1;
`endif
    end else if (En_in) begin
      samples_q[wr_ptr_q] <= Count_in;
      wr_ptr_q   <= wr_ptr_q + DEPTH_LOG2'(1);
      fill_q     <= fill_d;
      zero_run_q <= zero_run_d;
      Sum        <= sum_d;
      Avg_valid  <= full_d;
      Filled     <= full_d;
      Stall      <= (zero_run_d == StallMax);
      if (full_d) Avg <= sum_d[SumW-1:DEPTH_LOG2];
`ifdef FILTER_MINMAX_EN
      // Reset values make the first sample load both extremes.
      if (Count_in > Max_out) Max_out <= Count_in;
      if (Count_in < Min_out) Min_out <= Count_in;
`endif
    end else begin
      Avg_valid <= 1'b0;
    end
  end

endmodule
